// File: rtl/jt89_pkg.sv
// Shared types and constants for the jt89 write scheduler and its optional
// register shadow.
package jt89_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [2:0] REG_TONE0 = 3'd0;
    localparam logic [2:0] REG_VOL0  = 3'd1;
    localparam logic [2:0] REG_TONE1 = 3'd2;
    localparam logic [2:0] REG_VOL1  = 3'd3;
    localparam logic [2:0] REG_TONE2 = 3'd4;
    localparam logic [2:0] REG_VOL2  = 3'd5;
    localparam logic [2:0] REG_NOISE = 3'd6;
    localparam logic [2:0] REG_VOL3  = 3'd7;

    localparam logic [9:0] TONE_RST  = 10'h000;
    localparam logic [3:0] VOL_RST   = 4'hF;
    localparam logic [2:0] NOISE_RST = 3'b100;

endpackage

// File: rtl/jt89_shadow.sv
// Mirror of the jt89 register file, updated on each byte the PSG consumes.
module jt89_shadow
    import jt89_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] din,
    input  logic [2:0] rd_addr,
    output logic [9:0] rd_data
);

    logic [2:0] idx;
    logic [9:0] tone [4];
    logic [3:0] vol  [4];
    logic [2:0] noise;
    logic [2:0] widx;

    // A latch byte retargets the index in the same write it lands in.
    assign widx = din[7] ? din[6:4] : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= REG_TONE0;
            noise <= NOISE_RST;
            for (int unsigned i = 0; i < 4; i++) begin
                tone[i] <= TONE_RST;
                vol[i]  <= VOL_RST;
            end
        end else if (we) begin
            if (din[7])
                idx <= din[6:4];
            if (widx == REG_NOISE) begin
                if (din[7])
                    noise <= din[2:0];
            end else if (widx[0]) begin
                vol[widx[2:1]] <= din[3:0];
            end else if (din[7]) begin
                tone[widx[2:1]][3:0] <= din[3:0];
            end else begin
                tone[widx[2:1]][9:4] <= din[5:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr == REG_NOISE)
            rd_data = {7'd0, noise};
        else if (rd_addr[0])
            rd_data = {6'd0, vol[rd_addr[2:1]]};
        else
            rd_data = tone[rd_addr[2:1]];
    end

endmodule

// File: rtl/jt89_wrsched.sv
// Round-robin, transaction-atomic scheduler for a single jt89 write port.
// Optional register shadow is enabled with `define JT89_SHADOW_EN.
module jt89_wrsched
    import jt89_pkg::*;
#(
    parameter int unsigned GAP     = 1,
    parameter int unsigned LOCK_TO = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    input  logic       a_last,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    input  logic       b_last,
    output logic       b_ready,
    output logic [1:0] gnt,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    output logic       busy,
    output logic       lock_err,
    input  logic [2:0] rd_addr,
    output logic [9:0] rd_data
);

    state_t     state;
    logic       prio_b;
    logic       last_r;
    logic [3:0] gap_cnt;
    logic [7:0] lock_cnt;
    logic       sel_b;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       pick_b;

    assign sel_b     = gnt[1];
    assign sel_valid = sel_b ? b_valid : a_valid;
    assign sel_data  = sel_b ? b_data  : a_data;
    assign sel_last  = sel_b ? b_last  : a_last;
    assign pick_b    = b_valid && (!a_valid || prio_b);

    assign a_ready = (state == ST_ISSUE) && gnt[0];
    assign b_ready = (state == ST_ISSUE) && gnt[1];
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            prio_b   <= 1'b0;
            last_r   <= 1'b0;
            gap_cnt  <= '0;
            lock_cnt <= '0;
            psg_wr_n <= 1'b1;
            psg_din  <= '0;
            lock_err <= 1'b0;
        end else begin
            lock_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (a_valid || b_valid) begin
                        gnt      <= pick_b ? 2'b10 : 2'b01;
                        lock_cnt <= '0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sel_valid) begin
                        psg_din  <= sel_data;
                        psg_wr_n <= 1'b0;
                        last_r   <= sel_last;
                        lock_cnt <= '0;
                        state    <= ST_WRITE;
                    end else if (clk_en) begin
                        // Stalled owner: revoke the grant after LOCK_TO strobes.
                        if (lock_cnt == 8'(LOCK_TO - 1)) begin
                            lock_err <= 1'b1;
                            gnt      <= '0;
                            prio_b   <= ~sel_b;
                            state    <= ST_IDLE;
                        end else begin
                            lock_cnt <= lock_cnt + 8'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (clk_en) begin
                        psg_wr_n <= 1'b1;
                        gap_cnt  <= 4'(GAP);
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (clk_en) begin
                        gap_cnt <= gap_cnt - 4'd1;
                        if (gap_cnt == 4'd1) begin
                            if (last_r) begin
                                gnt    <= '0;
                                prio_b <= ~sel_b;
                                state  <= ST_IDLE;
                            end else begin
                                state  <= ST_ISSUE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef JT89_SHADOW_EN
    logic sh_we;
    assign sh_we = (state == ST_WRITE) && clk_en;

    jt89_shadow u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (sh_we),
        .din     (psg_din),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data = '0;
`endif

endmodule
